// File: rtl/alu_control_seq.sv
// ALU control decoder with a multi-cycle mult/div sequencer.
// The decode path is purely combinational and does not depend on sequencer state.
// The sequencer accepts a mult/div, launches the MDU, stalls the pipeline for the
// unit's latency and then pulses the HI/LO write strobe. A flush aborts the sequence.
module alu_control_seq #(
    parameter int FUNCT_LENGTH   = 6,
    parameter int ALU_OP_LENGTH  = 4,
    parameter int CONTROL_LENGTH = 4,
    parameter int MULT_LATENCY   = 4,
    parameter int DIV_LATENCY    = 8
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      valid_in,
    input  logic                      flush,
    input  logic [FUNCT_LENGTH-1:0]   func,
    input  logic [ALU_OP_LENGTH-1:0]  alu_op,
    output logic [CONTROL_LENGTH-1:0] control,
    output logic                      alu_select,
    output logic                      stall,
    output logic                      mdu_start,
    output logic                      mdu_op,
    output logic                      mdu_wr,
    output logic                      busy
);

    localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [FUNCT_LENGTH-1:0] F_MULT = FUNCT_LENGTH'(6'b011000);
    localparam logic [FUNCT_LENGTH-1:0] F_DIV  = FUNCT_LENGTH'(6'b011010);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mdu_start_q, mdu_start_d;
    logic               mdu_op_q, mdu_op_d;
    logic               mdu_wr_q, mdu_wr_d;

    logic               is_mult;
    logic               is_div;
    logic               md_req;

    assign is_mult = (alu_op == '0) && (func == F_MULT);
    assign is_div  = (alu_op == '0) && (func == F_DIV);
    assign md_req  = valid_in && (is_mult || is_div);

    // ALU control decode: R-type funct when alu_op is zero, otherwise the op class.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path through the case statements can leave it unassigned (latch).
        control    = '0;
        alu_select = 1'b0;
        if (alu_op == '0) begin
            case (func)
                FUNCT_LENGTH'(6'b100000): control = CONTROL_LENGTH'(0);
                FUNCT_LENGTH'(6'b100010): control = CONTROL_LENGTH'(1);
                FUNCT_LENGTH'(6'b100001): control = CONTROL_LENGTH'(2);
                FUNCT_LENGTH'(6'b100011): control = CONTROL_LENGTH'(3);
                FUNCT_LENGTH'(6'b100100): control = CONTROL_LENGTH'(4);
                FUNCT_LENGTH'(6'b100110): control = CONTROL_LENGTH'(5);
                FUNCT_LENGTH'(6'b100111): control = CONTROL_LENGTH'(6);
                FUNCT_LENGTH'(6'b000000): control = CONTROL_LENGTH'(7);
                FUNCT_LENGTH'(6'b000100): control = CONTROL_LENGTH'(7);
                FUNCT_LENGTH'(6'b000010): control = CONTROL_LENGTH'(8);
                FUNCT_LENGTH'(6'b101010): control = CONTROL_LENGTH'(9);
                F_MULT:                   control = CONTROL_LENGTH'(10);
                F_DIV:                    control = CONTROL_LENGTH'(11);
                FUNCT_LENGTH'(6'b000110): control = CONTROL_LENGTH'(12);
                FUNCT_LENGTH'(6'b000011): control = CONTROL_LENGTH'(12);
                FUNCT_LENGTH'(6'b100101): control = CONTROL_LENGTH'(13);
                // Secondary ALU bank
                FUNCT_LENGTH'(6'b111111): begin control = CONTROL_LENGTH'(0); alu_select = 1'b1; end
                FUNCT_LENGTH'(6'b111110): begin control = CONTROL_LENGTH'(1); alu_select = 1'b1; end
                FUNCT_LENGTH'(6'b111101): begin control = CONTROL_LENGTH'(2); alu_select = 1'b1; end
                FUNCT_LENGTH'(6'b111011): begin control = CONTROL_LENGTH'(3); alu_select = 1'b1; end
                FUNCT_LENGTH'(6'b110111): begin control = CONTROL_LENGTH'(4); alu_select = 1'b1; end
                FUNCT_LENGTH'(6'b101111): begin control = CONTROL_LENGTH'(5); alu_select = 1'b1; end
                FUNCT_LENGTH'(6'b011111): begin control = CONTROL_LENGTH'(6); alu_select = 1'b1; end
                default:                  control = CONTROL_LENGTH'(0);
            endcase
        end else begin
            case (alu_op)
                ALU_OP_LENGTH'(1): control = CONTROL_LENGTH'(0);
                ALU_OP_LENGTH'(2): control = CONTROL_LENGTH'(2);
                ALU_OP_LENGTH'(3): control = CONTROL_LENGTH'(4);
                ALU_OP_LENGTH'(4): control = CONTROL_LENGTH'(5);
                ALU_OP_LENGTH'(5): control = CONTROL_LENGTH'(13);
                ALU_OP_LENGTH'(6): control = CONTROL_LENGTH'(9);
                ALU_OP_LENGTH'(7): control = CONTROL_LENGTH'(14);
                ALU_OP_LENGTH'(8): control = CONTROL_LENGTH'(3);
                default:           control = CONTROL_LENGTH'(0);
            endcase
        end
    end

    // Sequencer next-state and stall: accept in IDLE, count down in BUSY, write in DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mdu_start_d = 1'b0;
        mdu_op_d    = mdu_op_q;
        mdu_wr_d    = 1'b0;
        stall       = 1'b0;

        if (flush) begin
            // Abort: the instruction is squashed, so nothing upstream needs holding.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_req) begin
                        stall       = 1'b1;
                        state_d     = S_BUSY;
                        cnt_d       = is_div ? DIV_LOAD : MULT_LOAD;
                        mdu_op_d    = is_div;
                        mdu_start_d = 1'b1;
                    end
                end
                S_BUSY: begin
                    stall = 1'b1;
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        mdu_wr_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // The stalled instruction leaves now; its valid_in is not a new request.
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Sequencer state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mdu_start_q <= 1'b0;
            mdu_op_q    <= 1'b0;
            mdu_wr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mdu_start_q <= mdu_start_d;
            mdu_op_q    <= mdu_op_d;
            mdu_wr_q    <= mdu_wr_d;
        end
    end

    assign mdu_start = mdu_start_q;
    assign mdu_op    = mdu_op_q;
    assign mdu_wr    = mdu_wr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: two instances (latencies 4/8 and 1/2).
// The driver applies one directed vector per cycle just after the rising edge and
// queues the hand-computed outputs; the monitor pops and compares on the falling edge.
module tb_alu_control_seq;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;

    typedef struct {
        int         id;
        logic [3:0] control;
        logic       alu_select;
        logic       stall;
        logic       mdu_start;
        logic       mdu_op;
        logic       mdu_wr;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    logic       valid_a = 1'b0, flush_a = 1'b0;
    logic [5:0] func_a = F_ADD;
    logic [3:0] aluop_a = 4'd0;
    logic [3:0] control_a;
    logic       alu_select_a, stall_a, mdu_start_a, mdu_op_a, mdu_wr_a, busy_a;

    logic       valid_b = 1'b0, flush_b = 1'b0;
    logic [5:0] func_b = F_ADD;
    logic [3:0] aluop_b = 4'd0;
    logic [3:0] control_b;
    logic       alu_select_b, stall_b, mdu_start_b, mdu_op_b, mdu_wr_b, busy_b;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;
    int vec_id = 0;

    always #5 clk = ~clk;

    alu_control_seq #(
        .MULT_LATENCY(4),
        .DIV_LATENCY (8)
    ) dut_a (
        .clk       (clk),
        .rst_b     (rst_b),
        .valid_in  (valid_a),
        .flush     (flush_a),
        .func      (func_a),
        .alu_op    (aluop_a),
        .control   (control_a),
        .alu_select(alu_select_a),
        .stall     (stall_a),
        .mdu_start (mdu_start_a),
        .mdu_op    (mdu_op_a),
        .mdu_wr    (mdu_wr_a),
        .busy      (busy_a)
    );

    alu_control_seq #(
        .MULT_LATENCY(1),
        .DIV_LATENCY (2)
    ) dut_b (
        .clk       (clk),
        .rst_b     (rst_b),
        .valid_in  (valid_b),
        .flush     (flush_b),
        .func      (func_b),
        .alu_op    (aluop_b),
        .control   (control_b),
        .alu_select(alu_select_b),
        .stall     (stall_b),
        .mdu_start (mdu_start_b),
        .mdu_op    (mdu_op_b),
        .mdu_wr    (mdu_wr_b),
        .busy      (busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t x(input int ctrl, input bit sel, input bit stl, input bit sta,
                               input bit op, input bit wr, input bit bsy);
        exp_t e;
        e.id         = 0;
        e.control    = 4'(ctrl);
        e.alu_select = sel;
        e.stall      = stl;
        e.mdu_start  = sta;
        e.mdu_op     = op;
        e.mdu_wr     = wr;
        e.busy       = bsy;
        return e;
    endfunction

    // Called just after a rising edge: apply one vector, queue its expectation, advance a cycle.
    task automatic step(input bit on_b, input bit v, input bit f, input logic [5:0] fn,
                        input logic [3:0] op, input exp_t e);
        exp_t t;
        t    = e;
        t.id = vec_id++;
        if (on_b) begin
            valid_b = v; flush_b = f; func_b = fn; aluop_b = op;
            q_b.push_back(t);
        end else begin
            valid_a = v; flush_a = f; func_a = fn; aluop_a = op;
            q_a.push_back(t);
        end
        @(posedge clk);
        #1;
    endtask

    // Asserts rst_b between edges with idle inputs, checks both instances, releases before the next edge.
    task automatic reset_cycle();
        exp_t t;
        rst_b   = 1'b0;
        valid_a = 1'b0; flush_a = 1'b0; func_a = F_ADD; aluop_a = 4'd0;
        valid_b = 1'b0; flush_b = 1'b0; func_b = F_ADD; aluop_b = 4'd0;
        t    = x(0, 0, 0, 0, 0, 0, 0);
        t.id = vec_id++;
        q_a.push_back(t);
        q_b.push_back(t);
        @(negedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare queued expectations against what each instance presents this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check($sformatf("A[%0d] control", e.id),    32'(control_a),    32'(e.control));
            check($sformatf("A[%0d] alu_select", e.id), 32'(alu_select_a), 32'(e.alu_select));
            check($sformatf("A[%0d] stall", e.id),      32'(stall_a),      32'(e.stall));
            check($sformatf("A[%0d] mdu_start", e.id),  32'(mdu_start_a),  32'(e.mdu_start));
            check($sformatf("A[%0d] mdu_op", e.id),     32'(mdu_op_a),     32'(e.mdu_op));
            check($sformatf("A[%0d] mdu_wr", e.id),     32'(mdu_wr_a),     32'(e.mdu_wr));
            check($sformatf("A[%0d] busy", e.id),       32'(busy_a),       32'(e.busy));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check($sformatf("B[%0d] control", e.id),    32'(control_b),    32'(e.control));
            check($sformatf("B[%0d] alu_select", e.id), 32'(alu_select_b), 32'(e.alu_select));
            check($sformatf("B[%0d] stall", e.id),      32'(stall_b),      32'(e.stall));
            check($sformatf("B[%0d] mdu_start", e.id),  32'(mdu_start_b),  32'(e.mdu_start));
            check($sformatf("B[%0d] mdu_op", e.id),     32'(mdu_op_b),     32'(e.mdu_op));
            check($sformatf("B[%0d] mdu_wr", e.id),     32'(mdu_wr_b),     32'(e.mdu_wr));
            check($sformatf("B[%0d] busy", e.id),       32'(busy_b),       32'(e.busy));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        reset_cycle();

        // Decode sweep (no acceptance: valid low or alu_op non-zero)
        step(0, 0, 0, F_ADD,     4'd0, x(0,  0, 0, 0, 0, 0, 0));
        step(0, 0, 0, F_SUB,     4'd0, x(1,  0, 0, 0, 0, 0, 0));
        step(0, 0, 0, F_DIV,     4'd0, x(11, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 6'b111011, 4'd0, x(3,  1, 0, 0, 0, 0, 0));
        step(0, 0, 0, F_ADD,     4'd7, x(14, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 6'b101011, 4'd0, x(0,  0, 0, 0, 0, 0, 0));
        step(0, 1, 0, F_ADD,     4'd5, x(13, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0, F_MULT,    4'd2, x(2,  0, 0, 0, 0, 0, 0));

        // Mult, latency 4: stall cycles 0-4, start in 1, write in 5, busy 1-5
        step(0, 1, 0, F_MULT, 4'd0, x(10, 0, 1, 0, 0, 0, 0));
        step(0, 1, 0, F_MULT, 4'd0, x(10, 0, 1, 1, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, F_MULT, 4'd0, x(10, 0, 1, 0, 0, 0, 1));
        step(0, 1, 0, F_MULT, 4'd0, x(10, 0, 0, 0, 0, 1, 1));
        step(0, 0, 0, F_ADD,  4'd0, x(0,  0, 0, 0, 0, 0, 0));

        // Div, latency 8: stall cycles 0-8, write in 9
        step(0, 1, 0, F_DIV, 4'd0, x(11, 0, 1, 0, 0, 0, 0));
        step(0, 1, 0, F_DIV, 4'd0, x(11, 0, 1, 1, 1, 0, 1));
        for (int i = 0; i < 7; i++)
            step(0, 1, 0, F_DIV, 4'd0, x(11, 0, 1, 0, 1, 0, 1));
        step(0, 1, 0, F_DIV, 4'd0, x(11, 0, 0, 0, 1, 1, 1));
        // Back-to-back div accepted, then flushed in its 3rd BUSY cycle
        step(0, 1, 0, F_DIV, 4'd0, x(11, 0, 1, 0, 1, 0, 0));
        step(0, 1, 0, F_DIV, 4'd0, x(11, 0, 1, 1, 1, 0, 1));
        step(0, 1, 0, F_DIV, 4'd0, x(11, 0, 1, 0, 1, 0, 1));
        step(0, 1, 1, F_DIV, 4'd0, x(11, 0, 0, 0, 1, 0, 1));
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, F_ADD, 4'd0, x(0, 0, 0, 0, 1, 0, 0));

        // Asynchronous reset mid-mult
        step(0, 1, 0, F_MULT, 4'd0, x(10, 0, 1, 0, 1, 0, 0));
        step(0, 1, 0, F_MULT, 4'd0, x(10, 0, 1, 1, 0, 0, 1));
        step(0, 1, 0, F_MULT, 4'd0, x(10, 0, 1, 0, 0, 0, 1));
        reset_cycle();
        step(0, 0, 0, F_ADD, 4'd0, x(0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0, F_ADD, 4'd0, x(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++)
            step(0, 0, 0, F_ADD, 4'd0, x(0, 0, 0, 0, 0, 0, 0));

        // Instance B, mult latency 1: stall 2 cycles, start and write back to back
        step(1, 1, 0, F_MULT, 4'd0, x(10, 0, 1, 0, 0, 0, 0));
        step(1, 1, 0, F_MULT, 4'd0, x(10, 0, 1, 1, 0, 0, 1));
        step(1, 1, 0, F_MULT, 4'd0, x(10, 0, 0, 0, 0, 1, 1));
        step(1, 0, 0, F_ADD,  4'd0, x(0,  0, 0, 0, 0, 0, 0));
        // Flush in the accept cycle suppresses acceptance
        step(1, 1, 1, F_MULT, 4'd0, x(10, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, F_ADD,  4'd0, x(0,  0, 0, 0, 0, 0, 0));
        // Div latency 2 with flush in DONE: visible write stays, nothing follows
        step(1, 1, 0, F_DIV, 4'd0, x(11, 0, 1, 0, 0, 0, 0));
        step(1, 1, 0, F_DIV, 4'd0, x(11, 0, 1, 1, 1, 0, 1));
        step(1, 1, 0, F_DIV, 4'd0, x(11, 0, 1, 0, 1, 0, 1));
        step(1, 1, 1, F_DIV, 4'd0, x(11, 0, 0, 0, 1, 1, 1));
        step(1, 0, 0, F_ADD, 4'd0, x(0,  0, 0, 0, 1, 0, 0));
        step(1, 0, 0, F_ADD, 4'd0, x(0,  0, 0, 0, 1, 0, 0));

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && (q_a.size() > 0 || q_b.size() > 0); i++)
            @(posedge clk);
        check("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised, sequencing successor to the combinational ALU control decoder; sits in the decode/execute boundary of the MIPS pipeline.
- Decodes func/alu_op into ALU control and ALU-select as before, same cycle.
- Adds a multi-cycle sequencer for mult/div: launches the multiply/divide unit, holds a pipeline stall for a parametrised latency, then pulses a HI/LO write strobe.
- Supports flush (branch/exception) abort mid-operation.

Parameters:
- FUNCT_LENGTH, 6, width of func field
- ALU_OP_LENGTH, 4, width of alu_op from main control
- CONTROL_LENGTH, 4, width of ALU control output
- MULT_LATENCY, 4, execute cycles for mult (>=1)
- DIV_LATENCY, 8, execute cycles for div (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- valid_in  input  1  instruction in stage is valid
- flush  input  1  abort current instruction/sequence
- func  input  FUNCT_LENGTH  R-type funct field
- alu_op  input  ALU_OP_LENGTH  main-control ALU op class
- control  output  CONTROL_LENGTH  ALU operation select (combinational)
- alu_select  output  1  selects secondary ALU bank (combinational)
- stall  output  1  freeze upstream pipeline
- mdu_start  output  1  one-cycle launch pulse to mult/div unit (registered)
- mdu_op  output  1  0 = mult, 1 = div (registered, held during sequence)
- mdu_wr  output  1  one-cycle HI/LO write strobe (registered)
- busy  output  1  sequencer not in IDLE

Behaviour:
- Decode (combinational, independent of state), alu_select=0 unless noted.
- alu_op=0, func to control: 100000→0, 100010→1, 100001→2, 100011→3, 100100→4, 100110→5, 100111→6, 000000→7, 000100→7, 000010→8, 101010→9, 011000→10, 011010→11, 000110→12, 000011→12, 100101→13.
- alu_op=0, func to control with alu_select=1: 111111→0, 111110→1, 111101→2, 111011→3, 110111→4, 101111→5, 011111→6.
- alu_op=0, any other func → control 0.
- alu_op≠0: 1→0, 2→2, 3→4, 4→5, 5→13, 6→9, 7→14, 8→3, other→0.
- Multi-cycle op: valid_in=1 and alu_op=0 and func=011000 (mult) or 011010 (div).
- FSM states: IDLE, BUSY, DONE. Counter width $clog2(max(MULT_LATENCY,DIV_LATENCY))+1.
- IDLE, no flush, multi-cycle op present:
  - stall=1 combinationally in that cycle (accept cycle).
  - At the edge: state→BUSY, cnt←latency-1, mdu_op←(func==011010), mdu_start←1.
- BUSY:
  - stall=1; mdu_start is high only in the first BUSY cycle.
  - cnt decrements each cycle; when cnt==0 at the edge, state→DONE and mdu_wr←1.
- DONE:
  - stall=0, mdu_wr=1 for exactly this cycle.
  - valid_in is ignored (it is the same stalled instruction leaving); next edge→IDLE.
- Stall timing: total stall = 1 + latency cycles; mdu_wr is asserted latency+1 cycles after the accept cycle.
- flush=1 in any state:
  - Suppresses acceptance and forces stall=0 combinationally.
  - Next edge: state→IDLE, cnt←0, mdu_start←0, mdu_wr←0. mdu_op keeps its value.
  - A flush in the DONE cycle still forces mdu_wr←0 at that edge; the write already visible in DONE is not retracted.
- valid_in=0 or non-multi-cycle op in IDLE: stall=0, no state change.
- busy = (state≠IDLE).
- Reset (rst_b=0, asynchronous): state=IDLE, cnt=0, mdu_start=0, mdu_op=0, mdu_wr=0. Hence stall=0 and busy=0 unless the decode inputs request acceptance. Reset mid-sequence aborts with no mdu_wr.

Test Plan:
- Decode sweep: alu_op=0 with func 100000/100010/011010/111011 → control 0/1/11/3, alu_select 0/0/0/1. alu_op=7 → control 14; alu_op=0 with func 101011 → control 0.
- Mult with MULT_LATENCY=4: valid_in=1, func=011000 at cycle 0 → stall high cycles 0–4, mdu_start in cycle 1, mdu_op=0, mdu_wr in cycle 5 only, busy cycles 1–5.
- Div with DIV_LATENCY=8: func=011010 → stall for 9 cycles, mdu_op=1, single mdu_wr in cycle 9; back-to-back div presented in cycle 10 is accepted normally.
- Flush in the 3rd BUSY cycle of a div → stall=0 that cycle, IDLE next cycle, mdu_wr never asserted.
- rst_b pulsed low asynchronously mid-mult (between clock edges) → outputs clear immediately; after release, a plain add (func 100000) causes no stall.
- MULT_LATENCY=1 edge case: stall for 2 cycles, mdu_start and mdu_wr in consecutive cycles.
